// File: rtl/switch_allocator_if.sv
// Handshake bundle between the router datapath and the switch allocator.
//
// Handshake: an input's flit is offered while req[i]=1 and it is consumed in
// exactly the cycles where grant[i]=1; the source must hold flit_id/dest
// stable until that grant. Downstream output o accepts a flit in any cycle
// where out_ready[o]=1. A grant is only ever issued when the owning input
// requests, the locked output is ready and the destination matches.
interface switch_allocator_if;
  logic [4:0]  req;
  logic [14:0] flit_id;
  logic [14:0] dest;
  logic [4:0]  out_ready;
  logic [4:0]  grant;
  logic [14:0] sel;
  logic [4:0]  sel_valid;
  logic [4:0]  timeout;
  // Debug view of the per-output round-robin pointers, [3o+2:3o] for output o.
  logic [14:0] ptr;

  modport master (
    output req,
    output flit_id,
    output dest,
    output out_ready,
    input  grant,
    input  sel,
    input  sel_valid,
    input  timeout,
    input  ptr
  );

  modport slave (
    input  req,
    input  flit_id,
    input  dest,
    input  out_ready,
    output grant,
    output sel,
    output sel_valid,
    output timeout,
    output ptr
  );
endinterface

// File: rtl/switch_allocator.sv
// Output-port allocator for a 5-port wormhole router.
// Each output has its own round-robin arbiter and lock FSM; the winning input
// holds the output from its header to its tail. A per-output watchdog frees an
// output whose owner stops sending for TIMEOUT consecutive cycles.
module switch_allocator #(
  parameter int NPORT   = 5,
  parameter int TIMEOUT = 64,
  parameter int CW      = 12
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Registered per-output state.
  state_t          state   [NPORT];
  logic [2:0]      owner   [NPORT];
  logic [2:0]      ptr_q   [NPORT];
  logic [CW-1:0]   cnt     [NPORT];
  logic [NPORT-1:0] timeout_q;

  // Per-input decoded views of the flat input buses.
  logic [2:0]       dest_of  [NPORT];
  logic [NPORT-1:0] hdr_bit;
  logic [NPORT-1:0] tail_bit;
  logic             unused_id_bits;

  // Per-output combinational decisions.
  logic [NPORT-1:0] cand     [NPORT];
  logic [NPORT-1:0] win_valid;
  logic [2:0]       winner   [NPORT];
  logic [NPORT-1:0] out_grant;
  logic [NPORT-1:0] tail_grant;
  logic [2:0]       next_ptr [NPORT];
  logic [NPORT-1:0] grant_c;

  // Split the flat buses into per-input fields; bit1 of the id (body marker)
  // carries no decision of its own.
  always_comb begin
    unused_id_bits = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      dest_of[i]     = bus.dest[3*i +: 3];
      hdr_bit[i]     = bus.flit_id[3*i];
      tail_bit[i]    = bus.flit_id[3*i+2];
      unused_id_bits = unused_id_bits ^ bus.flit_id[3*i+1];
    end
  end

  // Candidates for an idle output: requesting header/single flits aimed at it.
  // Destinations 5..7 never match any output and are therefore never served.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        cand[o][i] = bus.req[i] & hdr_bit[i] & (dest_of[i] == 3'(o));
      end
    end
  end

  // Round-robin pick: scan from ptr[o] upward modulo NPORT, first candidate wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_valid = '0;
    for (int o = 0; o < NPORT; o++) begin
      winner[o] = '0;
      for (int k = 0; k < NPORT; k++) begin
        idx = int'(ptr_q[o]) + k;
        if (idx >= NPORT) idx = idx - NPORT;
        if (!win_valid[o] && cand[o][idx]) begin
          win_valid[o] = 1'b1;
          winner[o]    = 3'(idx);
        end
      end
    end
  end

  // Locked-output grant: owner requests, downstream ready, dest still matches.
  // Reset suppresses every grant.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      out_grant[o]  = !rst && (state[o] == LOCKED) && bus.req[owner[o]] &&
                      bus.out_ready[o] && (dest_of[owner[o]] == 3'(o));
      tail_grant[o] = out_grant[o] && tail_bit[owner[o]];
      next_ptr[o]   = (owner[o] == 3'(NPORT-1)) ? 3'd0 : owner[o] + 3'd1;
    end
  end

  // Fold per-output grants onto the owning inputs.
  always_comb begin
    grant_c = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (out_grant[o]) grant_c[owner[o]] = 1'b1;
    end
  end

  // Per-output lock FSM with round-robin pointer and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NPORT; o++) begin
        state[o] <= IDLE;
        owner[o] <= '0;
        ptr_q[o] <= '0;
        cnt[o]   <= '0;
      end
      timeout_q <= '0;
    end else begin
      timeout_q <= '0;
      for (int o = 0; o < NPORT; o++) begin
        case (state[o])
          IDLE: begin
            if (win_valid[o]) begin
              state[o] <= LOCKED;
              owner[o] <= winner[o];
              cnt[o]   <= '0;
            end
          end
          LOCKED: begin
            if (tail_grant[o]) begin
              state[o] <= IDLE;
              ptr_q[o] <= next_ptr[o];
              cnt[o]   <= '0;
            end else if (out_grant[o]) begin
              cnt[o] <= '0;
            end else if ((TIMEOUT != 0) && (cnt[o] == CW'(TIMEOUT - 1))) begin
              state[o]     <= IDLE;
              ptr_q[o]     <= next_ptr[o];
              cnt[o]       <= '0;
              timeout_q[o] <= 1'b1;
            end else begin
              cnt[o] <= cnt[o] + CW'(1);
            end
          end
          default: state[o] <= IDLE;
        endcase
      end
    end
  end

  // Registered outputs are straight views of the lock state.
  always_comb begin
    bus.sel       = '0;
    bus.sel_valid = '0;
    bus.ptr       = '0;
    for (int o = 0; o < NPORT; o++) begin
      bus.sel[3*o +: 3] = owner[o];
      bus.sel_valid[o]  = (state[o] == LOCKED);
      bus.ptr[3*o +: 3] = ptr_q[o];
    end
  end

  assign bus.grant   = grant_c;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed packet scenarios followed
// by randomized traffic, all compared cycle by cycle against a behavioural
// model of the allocation rules.
module tb_switch_allocator;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_allocator_if bus();

  switch_allocator #(.NPORT(5), .TIMEOUT(TO), .CW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model of the outputs.
  bit m_lock [5];
  int m_own  [5];
  int m_sel  [5];
  int m_ptr  [5];
  int m_cnt  [5];
  bit m_to   [5];

  // Packet sources, one per input.
  bit s_act  [5];
  bit s_mute [5];
  int s_len  [5];
  int s_pos  [5];
  int s_dest [5];

  logic [4:0] rdy_v     = '1;
  bit         rand_mode = 1'b0;
  int         gcount   [5];
  int         to_count [5];
  int         hdr_order[$];
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [2:0] id_for(input int i);
    if (!s_act[i])              return 3'b000;
    if (s_len[i] == 1)          return 3'b101;
    if (s_pos[i] == 0)          return 3'b001;
    if (s_pos[i] == s_len[i]-1) return 3'b100;
    return 3'b010;
  endfunction

  task automatic start_pkt(input int i, input int d, input int len);
    s_act[i]  = 1'b1;
    s_len[i]  = len;
    s_pos[i]  = 0;
    s_dest[i] = d;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 5; i++) begin
      gcount[i]   = 0;
      to_count[i] = 0;
    end
    hdr_order.delete();
  endtask

  // ---------------- driver + scoreboard, one clock cycle ----------------
  task automatic cycle();
    logic [4:0]  r, rdy, eg;
    logic [14:0] f, d, exp_sel, exp_ptr;
    logic [4:0]  exp_sv, exp_to;
    int          own, idx;
    bit          g, found;
    for (int i = 0; i < 5; i++) begin
      r[i] = s_act[i] && !s_mute[i] && !(rand_mode && $urandom_range(0, 7) == 0);
      f[3*i +: 3] = id_for(i);
      d[3*i +: 3] = s_act[i] ? 3'(s_dest[i]) : 3'd0;
      rdy[i] = rand_mode ? ($urandom_range(0, 3) != 0) : rdy_v[i];
    end
    bus.req = r; bus.flit_id = f; bus.dest = d; bus.out_ready = rdy;

    @(negedge clk);
    for (int o = 0; o < 5; o++) begin
      exp_sv[o] = m_lock[o];
      exp_to[o] = m_to[o];
      exp_sel[3*o +: 3] = 3'(m_sel[o]);
      exp_ptr[3*o +: 3] = 3'(m_ptr[o]);
    end
    check("sel_valid", bus.sel_valid, exp_sv);
    check("timeout",   bus.timeout,   exp_to);
    check("sel",       bus.sel,       exp_sel);
    check("ptr",       bus.ptr,       exp_ptr);

    eg = '0;
    for (int o = 0; o < 5; o++) begin
      own = m_own[o];
      if (!rst && m_lock[o] && r[own] && rdy[o] && (int'(d[3*own +: 3]) == o)) eg[own] = 1'b1;
    end
    exp_q.push_back(eg);
    check("grant", bus.grant, exp_q.pop_front());

    for (int i = 0; i < 5; i++) begin
      if (bus.grant[i]) begin
        gcount[i]++;
        if (s_pos[i] == 0) hdr_order.push_back(i);
      end
      to_count[i] += int'(bus.timeout[i]);
    end

    // Model next state.
    for (int o = 0; o < 5; o++) m_to[o] = 1'b0;
    if (rst) begin
      for (int o = 0; o < 5; o++) begin
        m_lock[o] = 0; m_own[o] = 0; m_sel[o] = 0; m_ptr[o] = 0; m_cnt[o] = 0;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (!m_lock[o]) begin
          found = 1'b0;
          for (int k = 0; k < 5; k++) begin
            idx = (m_ptr[o] + k) % 5;
            if (!found && r[idx] && int'(d[3*idx +: 3]) == o && f[3*idx]) begin
              found = 1'b1;
              m_lock[o] = 1; m_own[o] = idx; m_sel[o] = idx; m_cnt[o] = 0;
            end
          end
        end else begin
          own = m_own[o];
          g = r[own] && rdy[o] && (int'(d[3*own +: 3]) == o);
          if (g && f[3*own+2]) begin
            m_lock[o] = 0; m_ptr[o] = (own + 1) % 5; m_cnt[o] = 0;
          end else if (g) begin
            m_cnt[o] = 0;
          end else if (TO != 0 && m_cnt[o] == TO - 1) begin
            m_lock[o] = 0; m_ptr[o] = (own + 1) % 5; m_cnt[o] = 0; m_to[o] = 1;
          end else begin
            m_cnt[o]++;
          end
        end
      end
    end

    // Sources advance on the grants the rules call for.
    for (int i = 0; i < 5; i++) begin
      if (eg[i]) begin
        s_pos[i]++;
        if (s_pos[i] >= s_len[i]) s_act[i] = 1'b0;
      end
    end

    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < bound) begin
      busy = 1'b0;
      for (int i = 0; i < 5; i++) if (s_act[i]) busy = 1'b1;
      if (busy) begin
        cycle();
        n++;
      end
    end
    if (busy) check({tag, "_drain_bound"}, 32'd1, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req = '0; bus.flit_id = '0; bus.dest = '0; bus.out_ready = '1;
    for (int i = 0; i < 5; i++) begin
      s_act[i] = 0; s_mute[i] = 0; s_len[i] = 0; s_pos[i] = 0; s_dest[i] = 0;
      m_lock[i] = 0; m_own[i] = 0; m_sel[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0; m_to[i] = 0;
    end
    clear_stats();

    // Reset state.
    rst = 1'b1;
    run_cycles(2);
    check("reset_grant", bus.grant, 5'd0);
    rst = 1'b0;
    run_cycles(1);

    // 1) Three-flit packet input 0 -> output 1.
    clear_stats();
    start_pkt(0, 1, 3);
    drain("t1", 20);
    run_cycles(2);
    check("t1_grants", gcount[0], 3);
    check("t1_unlocked", bus.sel_valid[1], 1'b0);
    check("t1_ptr1", bus.ptr[5:3], 3'd1);

    // 2) Inputs 0, 2, 4 compete for output 3.
    clear_stats();
    start_pkt(0, 3, 2); start_pkt(2, 3, 2); start_pkt(4, 3, 2);
    drain("t2", 40);
    run_cycles(2);
    check("t2_count", hdr_order.size(), 3);
    if (hdr_order.size() == 3) begin
      check("t2_first",  hdr_order[0], 0);
      check("t2_second", hdr_order[1], 2);
      check("t2_third",  hdr_order[2], 4);
    end
    check("t2_ptr3", bus.ptr[11:9], 3'd0);

    // 3) Owner 2 on output 1 stalls on out_ready for 4 cycles.
    start_pkt(2, 1, 4);
    run_cycles(3);
    clear_stats();
    rdy_v[1] = 1'b0;
    run_cycles(4);
    check("t3_stall_grants", gcount[2], 0);
    check("t3_lock_held", bus.sel_valid[1], 1'b1);
    check("t3_sel_held", bus.sel[5:3], 3'd2);
    rdy_v[1] = 1'b1;
    drain("t3", 20);
    check("t3_no_timeout", to_count[1], 0);

    // 4) Owner goes silent after its header; watchdog hands output 4 to input 3.
    start_pkt(1, 4, 3);
    run_cycles(2);
    s_mute[1] = 1'b1;
    start_pkt(3, 4, 1);
    clear_stats();
    for (int k = 0; k < 30 && s_act[3]; k++) cycle();
    check("t4_timeouts", to_count[4], 1);
    check("t4_waiter_grant", gcount[3], 1);
    s_act[1] = 1'b0; s_mute[1] = 1'b0;
    run_cycles(2);

    // 5) Single-flit packet input 3 -> output 0.
    clear_stats();
    start_pkt(3, 0, 1);
    run_cycles(2);
    check("t5_idle_again", bus.sel_valid[0], 1'b0);
    run_cycles(3);
    check("t5_grants", gcount[3], 1);

    // 6) Reset mid-packet, then orphaned body flit and an unservable dest.
    start_pkt(0, 2, 4);
    run_cycles(2);
    rst = 1'b1;
    run_cycles(1);
    rst = 1'b0;
    check("t6_locks_dropped", bus.sel_valid, 5'd0);
    start_pkt(4, 6, 2);
    clear_stats();
    run_cycles(10);
    check("t6_body_grants", gcount[0], 0);
    check("t6_dest6_grants", gcount[4], 0);
    s_act[0] = 1'b0; s_act[4] = 1'b0;
    run_cycles(2);

    // Randomized traffic.
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (!s_act[i] && $urandom_range(0, 3) == 0)
          start_pkt(i, ($urandom_range(0, 9) < 9) ? $urandom_range(0, 4) : $urandom_range(5, 7),
                    $urandom_range(1, 4));
        else if (s_act[i] && $urandom_range(0, 63) == 0)
          s_act[i] = 1'b0;
      end
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end
endmodule
